adc_avg_display: RTL and testbench
==================================

# adc_avg_display

Downstream stage of `adc_controller`. It takes each 8-bit conversion result the controller latches, keeps a moving average over the last 2^LOG2_N samples, and drives the 8-LED bar graph and the peak-hold register. It replaces direct raw-sample display with a filtered, registered output.

## Interface
- `LOG2_N`, default 3: log2 of the averaging window, giving 8 samples. Legal range is 1..5.
- `PEAK_HOLD_CYCLES`, default 1000: number of clk cycles the peak is held after its last rise. Must be ≥ 1.

- `clk`, input, 1: system clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `sample_valid`, input, 1: one-cycle strobe from `adc_controller` when a new result is latched.
- `sample`, input, 8: conversion result, qualified by `sample_valid`.
- `clear`, input, 1: synchronous flush of the window. It has the same effect as reset on all state.
- `avg`, output, 8: registered window average.
- `avg_valid`, output, 1: one-cycle pulse when `avg` has been updated.
- `window_full`, output, 1: high once 2^LOG2_N samples have been accepted since reset or clear.
- `bar`, output, 8: thermometer code of `avg` for the LEDs.
- `peak`, output, 8: peak-hold of `avg`.

## Operation
- **Storage:** circular buffer of 2^LOG2_N × 8-bit entries, plus write pointer `wptr` (LOG2_N bits, wraps from 2^LOG2_N−1 to 0).
- **Fill counter:** `fill_cnt`, 0..2^LOG2_N.
- **Running sum:** `sum`, 8+LOG2_N bits unsigned; it never overflows.
- **FSM states:**
  - FILLING: the reset state.
  - RUNNING: entered on the sample that makes `fill_cnt` = 2^LOG2_N.
  - Only reset or `clear` returns the FSM to FILLING.
- **On an accepted sample** (`sample_valid` high and `clear` low):
  - `sum <= sum + sample − buf[wptr]`. Buffer entries are 0 after reset/clear, so the subtraction is exact during FILLING.
  - `buf[wptr] <= sample`.
  - `wptr <= wptr + 1`.
  - `fill_cnt` saturates at 2^LOG2_N.
- **Average output:** `avg <= sum_next >> LOG2_N` (truncating). It is updated only when the accepted sample leaves the FSM in RUNNING; at that point `avg_valid` pulses. During FILLING, `avg`, `bar` and `peak` hold 0 and `avg_valid` stays 0.
- **Bar graph:** registered in the same cycle as `avg`.
  - k = (avg + 16) >> 5, computed 9-bit, range 0..8.
  - `bar[i] = (i < k)`.
  - Examples: avg 0 gives 0x00; avg 0x6C gives 0x07; avg 0xFF gives 0xFF.
- **Peak hold:** `hold_cnt` is sized for PEAK_HOLD_CYCLES.
  - When `avg_valid` fires with new avg > `peak`: `peak <= new avg` and `hold_cnt <= PEAK_HOLD_CYCLES−1`.
  - Otherwise, if `hold_cnt` ≠ 0: decrement it every cycle.
  - Otherwise, if `hold_cnt` = 0 and `peak` > `avg`: `peak <= avg` and `hold_cnt` reloads. This is a step decay to the current average.
  - When a new higher avg and hold expiry happen in the same cycle, the new higher avg wins.
- **Clear/reset:** `clear` or `rst_n` low zeroes buffer, `sum`, `wptr`, `fill_cnt`, `avg`, `bar`, `peak` and `hold_cnt`, and forces FILLING. If `clear` and `sample_valid` are high together, the sample is dropped.

## Timing
- **Reset values:** `avg`=0x00, `avg_valid`=0, `window_full`=0, `bar`=0x00, `peak`=0x00.
- **Latency:** 1 clk. Sample accepted on edge n gives `avg`/`bar` valid and `avg_valid`=1 after edge n; `peak` updates on the same edge.
- **`window_full`:** rises on the edge that accepts sample number 2^LOG2_N and stays high until reset/clear.
- **Throughput:** `sample_valid` may be asserted every cycle, including back-to-back; each strobe is accepted.
- **`sample` outside `sample_valid`:** ignored.
- **Reset or clear mid-fill / mid-run:** takes effect on that edge. The next sample restarts the window with `fill_cnt`=1.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with `sample_valid` toggling. All outputs read 0, and no `avg_valid` appears.
2. **Fill and first average** (LOG2_N=3): send 8 strobes of 0x6C. `avg_valid` stays 0 for strobes 1–7. One clk after strobe 8: `avg`=0x6C, `avg_valid`=1 for one cycle, `window_full`=1, `bar`=0x07, `peak`=0x6C.
3. **Step response:** continue with 8 back-to-back strobes of 0xFF.
   - First update: `avg`=0x7E (sum 1011).
   - Subsequent updates increase `avg` on every strobe.
   - After the 8th: `avg`=0xFF, `bar`=0xFF, `peak`=0xFF.
4. **Peak hold** (PEAK_HOLD_CYCLES=20): after `peak`=0xFF, send 8 strobes of 0x00. `avg` reaches 0x00 and `bar`=0x00. `peak` stays 0xFF for 20 cycles counted from the cycle it loaded, then steps to 0x00.
5. **Clear collision:** in RUNNING, assert `clear` and `sample_valid`=0x80 in the same cycle. The sample is dropped and all outputs go to 0. The next 7 strobes produce no `avg_valid`; the 8th does.
6. **Reset mid-fill:** after 5 strobes, pulse `rst_n` low for one cycle. 8 further strobes of 0x40 are needed for the first `avg_valid`, which then gives `avg`=0x40 and `bar`=0x03.

Source files
------------

// File: rtl/adc_avg_display.sv
// Moving average of the last 2^LOG2_N ADC samples, driving an 8-LED bar graph and a peak-hold register.
// One clk from accepted sample to avg/bar/peak; every strobe is accepted, clear drops a coincident sample.
module adc_avg_display #(
  parameter int LOG2_N           = 3,
  parameter int PEAK_HOLD_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sample_valid,
  input  logic [7:0] i_sample,
  input  logic       i_clear,
  output logic [7:0] o_avg,
  output logic       o_avg_valid,
  output logic       o_window_full,
  output logic [7:0] o_bar,
  output logic [7:0] o_peak
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 8 + LOG2_N;
  localparam int HW = (PEAK_HOLD_CYCLES > 1) ? $clog2(PEAK_HOLD_CYCLES) : 1;

  localparam logic [HW-1:0]   HOLD_RELOAD = HW'(PEAK_HOLD_CYCLES - 1);
  localparam logic [LOG2_N:0] FILL_MAX    = (LOG2_N + 1)'(N);

  localparam logic [0:0] ST_FILLING = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  logic [7:0]        r_buf [N];
  logic [LOG2_N-1:0] r_wptr;
  logic [LOG2_N:0]   r_fill_cnt;
  logic [SW-1:0]     r_sum;
  logic [0:0]        r_state;
  logic [7:0]        r_avg;
  logic              r_avg_valid;
  logic [7:0]        r_bar;
  logic [7:0]        r_peak;
  logic [HW-1:0]     r_hold_cnt;

  logic              w_accept;
  logic [SW-1:0]     w_sum_next;
  logic [LOG2_N:0]   w_fill_next;
  logic              w_running_next;
  logic              w_upd;
  logic [7:0]        w_avg_new;
  logic [7:0]        w_avg_cur;
  logic [8:0]        w_bar_k;
  logic [7:0]        w_bar_new;

  assign w_accept       = i_sample_valid & ~i_clear;
  // Modular arithmetic: a transient wrap in sum+sample cancels after the subtraction.
  assign w_sum_next     = r_sum + SW'(i_sample) - SW'(r_buf[r_wptr]);
  assign w_fill_next    = (r_fill_cnt == FILL_MAX) ? FILL_MAX : r_fill_cnt + (LOG2_N + 1)'(1);
  assign w_running_next = (r_state == ST_RUNNING) | (w_fill_next == FILL_MAX);
  assign w_upd          = w_accept & w_running_next;
  assign w_avg_new      = w_sum_next[SW-1:LOG2_N];
  assign w_avg_cur      = w_upd ? w_avg_new : r_avg;
  assign w_bar_k        = ({1'b0, w_avg_new} + 9'd16) >> 5;

  always_comb begin
    w_bar_new = '0;
    for (int i = 0; i < 8; i++) begin
      w_bar_new[i] = (9'(i) < w_bar_k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
      r_wptr      <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_state     <= ST_FILLING;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_bar       <= '0;
      r_peak      <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_avg_valid <= w_upd;

      if (w_accept) begin
        r_sum         <= w_sum_next;
        r_buf[r_wptr] <= i_sample;
        r_wptr        <= r_wptr + LOG2_N'(1);
        r_fill_cnt    <= w_fill_next;
        if (w_running_next) r_state <= ST_RUNNING;
      end

      if (w_upd) begin
        r_avg <= w_avg_new;
        r_bar <= w_bar_new;
      end

      // A new higher average beats hold expiry; expiry steps the peak down to the current average.
      if (w_upd && (w_avg_new > r_peak)) begin
        r_peak     <= w_avg_new;
        r_hold_cnt <= HOLD_RELOAD;
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - HW'(1);
      end else if (r_peak > w_avg_cur) begin
        r_peak     <= w_avg_cur;
        r_hold_cnt <= HOLD_RELOAD;
      end
    end
  end

  assign o_avg         = r_avg;
  assign o_avg_valid   = r_avg_valid;
  assign o_window_full = (r_state == ST_RUNNING);
  assign o_bar         = r_bar;
  assign o_peak        = r_peak;

endmodule

// File: tb/tb_adc_avg_display.sv
// Directed bench for adc_avg_display: a queue-based window model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_adc_avg_display;

  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;
  localparam int PHC    = 20;

  logic       clk;
  logic       rst_n;
  logic       sv;
  logic [7:0] smp;
  logic       clr;
  logic [7:0] o_avg;
  logic       o_avg_valid;
  logic       o_window_full;
  logic [7:0] o_bar;
  logic [7:0] o_peak;

  int checks   = 0;
  int failures = 0;

  adc_avg_display #(.LOG2_N(LOG2_N), .PEAK_HOLD_CYCLES(PHC)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_valid (sv),
    .i_sample       (smp),
    .i_clear        (clr),
    .o_avg          (o_avg),
    .o_avg_valid    (o_avg_valid),
    .o_window_full  (o_window_full),
    .o_bar          (o_bar),
    .o_peak         (o_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window model: the last N accepted samples, their mean, and peak timestamps.
  logic [7:0] q[$];
  logic       armed = 1'b0;
  int         cyc_n = 0;
  int         m_avg, m_bar, m_peak, m_load;
  logic       m_valid;

  always @(posedge clk) begin
    int s;
    int k;
    cyc_n++;
    if (!rst_n || clr) begin
      armed   = 1'b1;
      q.delete();
      m_avg   = 0;
      m_bar   = 0;
      m_peak  = 0;
      m_valid = 1'b0;
      m_load  = cyc_n - PHC;
    end else if (armed) begin
      m_valid = 1'b0;
      if (sv) begin
        q.push_back(smp);
        if (q.size() > N) void'(q.pop_front());
        if (q.size() == N) begin
          s = 0;
          foreach (q[i]) s += int'(q[i]);
          m_avg   = s / N;
          k       = (m_avg + 16) / 32;
          m_bar   = (1 << k) - 1;
          m_valid = 1'b1;
        end
      end
      if (m_valid && m_avg > m_peak) begin
        m_peak = m_avg;
        m_load = cyc_n;
      end else if ((cyc_n - m_load) >= PHC && m_peak > m_avg) begin
        m_peak = m_avg;
        m_load = cyc_n;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_avg", 32'(o_avg), 32'(m_avg));
      chk("cyc_avg_valid", 32'(o_avg_valid), 32'(m_valid));
      chk("cyc_window_full", 32'(o_window_full), 32'(q.size() == N));
      chk("cyc_bar", 32'(o_bar), 32'(m_bar));
      chk("cyc_peak", 32'(o_peak), 32'(m_peak));
    end
  end

  // Drives inputs for the next rising edge; on return, outputs reflect the previous edge.
  task automatic cyc(input logic vld, input logic [7:0] d, input logic c, input logic rn);
    @(negedge clk);
    sv    = vld;
    smp   = d;
    clr   = c;
    rst_n = rn;
  endtask

  initial begin
    int hold_obs;
    int pulses;
    rst_n = 1'b0;
    sv    = 1'b0;
    smp   = 8'h00;
    clr   = 1'b0;

    // Reset with strobes toggling
    for (int i = 0; i < 3; i++) cyc(logic'(i % 2 == 0), 8'h55, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_avg", 32'(o_avg), 32'h00);
    chk("rst_valid", 32'(o_avg_valid), 32'h0);
    chk("rst_full", 32'(o_window_full), 32'h0);
    chk("rst_bar", 32'(o_bar), 32'h00);
    chk("rst_peak", 32'(o_peak), 32'h00);

    // Fill with 0x6C
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h6C, 1'b0, 1'b1);
      if (o_avg_valid) pulses++;
      if (i == 7) chk("fill7_full", 32'(o_window_full), 32'h0);
    end
    chk("fill_no_early_valid", 32'(pulses), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_avg", 32'(o_avg), 32'h6C);
    chk("fill_valid", 32'(o_avg_valid), 32'h1);
    chk("fill_full", 32'(o_window_full), 32'h1);
    chk("fill_bar", 32'(o_bar), 32'h07);
    chk("fill_peak", 32'(o_peak), 32'h6C);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_valid_one_cycle", 32'(o_avg_valid), 32'h0);

    // Step to 0xFF, back-to-back
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hFF, 1'b0, 1'b1);
      if (i == 1) begin
        chk("step_first_avg", 32'(o_avg), 32'h7E);
        chk("step_first_bar", 32'(o_bar), 32'h0F);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("step_avg", 32'(o_avg), 32'hFF);
    chk("step_bar", 32'(o_bar), 32'hFF);
    chk("step_peak", 32'(o_peak), 32'hFF);

    // Peak hold: count observations of 0xFF since the load edge
    hold_obs = 1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h00, 1'b0, 1'b1);
      if (o_peak == 8'hFF) hold_obs++;
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      if (o_peak == 8'hFF) hold_obs++;
      else break;
    end
    chk("hold_cycles", 32'(hold_obs), 32'd20);
    chk("hold_decay_peak", 32'(o_peak), 32'h00);
    chk("hold_avg", 32'(o_avg), 32'h00);
    chk("hold_bar", 32'(o_bar), 32'h00);

    // Clear collides with a 0x80 strobe
    cyc(1'b1, 8'h80, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_full", 32'(o_window_full), 32'h0);
    chk("clr_avg", 32'(o_avg), 32'h00);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h20, 1'b0, 1'b1);
      if (o_avg_valid) pulses++;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_no_early_valid", 32'(pulses), 32'd0);
    chk("clr_valid", 32'(o_avg_valid), 32'h1);
    chk("clr_avg_after", 32'(o_avg), 32'h20);
    chk("clr_bar_after", 32'(o_bar), 32'h01);

    // Reset mid-fill
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h90, 1'b0, 1'b1);
    cyc(1'b1, 8'h90, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'h40, 1'b0, 1'b1);
      if (o_avg_valid) pulses++;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rmid_no_early_valid", 32'(pulses), 32'd0);
    chk("rmid_valid", 32'(o_avg_valid), 32'h1);
    chk("rmid_avg", 32'(o_avg), 32'h40);
    chk("rmid_bar", 32'(o_bar), 32'h03);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
